// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage SPARC pipeline.
// Handles load-use hazards, taken/annulled branches and data-memory waits.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   id_* / ex_*             hazard sources from the ID and EX stages
//   mem_req, mem_ready      data-memory handshake seen in MEM
//   pc_hold .. exmem_hold   per-register hold / bubble controls
//   mem_timeout             sticky watchdog trap (cleared only by reset)
//   stall_cycles,
//   flush_events            perf counters, only with PIPE_PERF_CNT_EN
//
// Optional feature macro: PIPE_PERF_CNT_EN
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int PERF_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_br_taken,
    input  logic       ex_br_annul,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_hold,
    output logic       ifid_hold,
    output logic       ifid_flush,
    output logic       idex_hold,
    output logic       idex_flush,
    output logic       exmem_hold,
    output logic       mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        TRAP
    } state_t;

    state_t          state, state_n;
    logic [TO_W-1:0] wd, wd_n;
    logic            to_n;
    logic            mem_stall;
    logic            br_cyc;
    logic            load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign br_cyc    = ex_valid & (ex_br_taken | ex_br_annul);

    // %g0 reads as zero, so a load into r0 never creates a dependency.
    assign load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wd          <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wd          <= wd_n;
            mem_timeout <= to_n;
        end
    end

    always_comb begin
        state_n    = state;
        wd_n       = wd;
        to_n       = mem_timeout;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_hold  = 1'b1;
                    exmem_hold = 1'b1;
                    state_n    = MEMWAIT;
                    wd_n       = TO_W'(1);
                end else if (br_cyc) begin
                    ifid_flush = ex_br_taken;
                    idex_flush = ex_br_annul;
                end else if (load_use) begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            MEMWAIT: begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
                if (mem_ready) begin
                    state_n = RUN;
                    wd_n    = '0;
                end else begin
                    if (wd == TO_W'(TIMEOUT)) begin
                        state_n = TRAP;
                        to_n    = 1'b1;
                    end
                    // Saturate rather than wrap.
                    if (wd != '1)
                        wd_n = wd + 1'b1;
                end
            end
            TRAP: begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
            end
            default: state_n = RUN;
        endcase
        // Controls are forced quiet while reset is held, whatever the state.
        if (reset) begin
            pc_hold    = 1'b0;
            ifid_hold  = 1'b0;
            ifid_flush = 1'b0;
            idex_hold  = 1'b0;
            idex_flush = 1'b0;
            exmem_hold = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic any_hold;
    logic br_flush;

    assign any_hold = pc_hold | ifid_hold | idex_hold | exmem_hold;
    // Only branch-driven bubbles count as flush events.
    assign br_flush = (state == RUN) & ~mem_stall & br_cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (any_hold)
                stall_cycles <= stall_cycles + 1'b1;
            if (br_flush)
                flush_events <= flush_events + 1'b1;
        end
    end
`else
    if (PERF_W > 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized and directed bench for pipe_hazard_ctrl.
// Expected values come from a cycle-level behavioural model kept here.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_br_taken, ex_br_annul;
    logic       mem_req, mem_ready;
    logic       pc_hold, ifid_hold, ifid_flush;
    logic       idex_hold, idex_flush, exmem_hold, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [PW-1:0] stall_cycles, flush_events;
`endif
    logic [5:0] got;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_wait, m_trap, m_to;
    int m_cnt;
    int m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .TIMEOUT(TO),
        .TO_W   (8),
        .PERF_W (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_br_taken (ex_br_taken),
        .ex_br_annul (ex_br_annul),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .ifid_flush  (ifid_flush),
        .idex_hold   (idex_hold),
        .idex_flush  (idex_flush),
        .exmem_hold  (exmem_hold),
        .mem_timeout (mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    assign got = {pc_hold, ifid_hold, ifid_flush,
                  idex_hold, idex_flush, exmem_hold};

    function automatic bit m_lu();
        return ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
               ((id_use_rs1 && id_rs1 == ex_rd) ||
                (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // bits: pc_hold ifid_hold ifid_flush idex_hold idex_flush exmem_hold
    function automatic logic [5:0] m_out();
        if (reset) return 6'b000000;
        if (m_wait || m_trap) return 6'b110101;
        if (mem_req && !mem_ready) return 6'b110101;
        if (ex_valid && (ex_br_taken || ex_br_annul))
            return {2'b00, ex_br_taken, 1'b0, ex_br_annul, 1'b0};
        if (m_lu()) return 6'b110010;
        return 6'b000000;
    endfunction

    task automatic m_tick();
        logic [5:0] o;
        o = m_out();
        if (reset) begin
            m_wait = 0; m_trap = 0; m_to = 0; m_cnt = 0;
            m_stall = 0; m_flush = 0;
            return;
        end
        if (o[5] || o[4] || o[2] || o[0]) m_stall++;
        if (!m_wait && !m_trap && !(mem_req && !mem_ready) &&
            ex_valid && (ex_br_taken || ex_br_annul)) m_flush++;
        if (m_trap) begin
        end else if (m_wait) begin
            if (mem_ready) begin
                m_wait = 0; m_cnt = 0;
            end else begin
                if (m_cnt == TO) begin
                    m_wait = 0; m_trap = 1; m_to = 1;
                end
                if (m_cnt < 255) m_cnt++;
            end
        end else if (mem_req && !mem_ready) begin
            m_wait = 1; m_cnt = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_tick();
    endtask

    task automatic idle_in();
        reset = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0; ex_rd = 0;
        ex_is_load = 0; ex_br_taken = 0; ex_br_annul = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic rand_in();
        reset       = 0;
        id_valid    = 1'($urandom);
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_use_rs1  = 1'($urandom);
        id_use_rs2  = 1'($urandom);
        ex_valid    = 1'($urandom);
        ex_rd       = 5'($urandom_range(0, 3));
        ex_is_load  = 1'($urandom);
        ex_br_taken = ($urandom_range(0, 3) == 0);
        ex_br_annul = ($urandom_range(0, 3) == 0);
        mem_req     = ($urandom_range(0, 4) == 0);
        mem_ready   = ($urandom_range(0, 9) < 6);
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u1,
                          input logic u2);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_rs1 = r1; id_rs2 = r2;
        id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_in();
            reset = 1;
            #1;
            total++;
            if (got !== 6'b000000) begin
                bad++;
                $display("FAIL reset_out cyc%0d got=%b want=000000", i, got);
            end
            tick();
        end
        @(negedge clk);
        idle_in();
        #1;
        total++;
        if (got !== 6'b000000 || mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%b/%b want=000000/0",
                     got, mem_timeout);
        end
        tick();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            idle_in();
            case (i)
                0: set_lu(5, 5, 9, 1, 0);
                1: begin set_lu(5, 5, 9, 1, 0); ex_valid = 0; end
                2: set_lu(0, 7, 0, 0, 1);
                3: set_lu(5, 1, 5, 0, 0);
                4: set_lu(5, 1, 5, 0, 1);
                5: begin set_lu(5, 5, 5, 1, 1); id_valid = 0; end
                default: begin rand_in(); mem_req = 0; end
            endcase
            #1;
            total++;
            if (got !== m_out() || mem_timeout !== m_to) begin
                bad++;
                $display("FAIL load_use step%0d got=%b want=%b",
                         i, got, m_out());
            end
            tick();
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_in();
            ex_valid = 1;
            case (i)
                0: ex_br_taken = 1;
                1: begin ex_br_taken = 1; ex_br_annul = 1; end
                2: ex_br_annul = 1;
                3: begin set_lu(5, 5, 0, 1, 0); ex_br_taken = 1; end
                4: begin ex_valid = 0; ex_br_taken = 1; ex_br_annul = 1; end
                default: begin set_lu(6, 0, 6, 0, 1); ex_br_annul = 1; end
            endcase
            #1;
            total++;
            if (got !== m_out()) begin
                bad++;
                $display("FAIL branch step%0d got=%b want=%b",
                         i, got, m_out());
            end
            tick();
        end
    endtask

    task automatic test_memwait();
        int holds = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_in();
            set_lu(3, 3, 0, 1, 0);
            mem_req   = (i == 0);
            mem_ready = (i == 3);
            if (i == 5) ex_valid = 0;
            #1;
            if (exmem_hold) holds++;
            total++;
            if (got !== m_out() || mem_timeout !== m_to) begin
                bad++;
                $display("FAIL memwait step%0d got=%b want=%b",
                         i, got, m_out());
            end
            tick();
        end
        total++;
        if (holds != 4) begin
            bad++;
            $display("FAIL memwait_len got=%0d want=4", holds);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle_in();
            reset     = (i == 0 || i == 10);
            mem_req   = 1;
            mem_ready = (i == 9);
            if (i >= 7) rand_in();
            if (i == 10) reset = 1;
            if (i == 11) idle_in();
            #1;
            total++;
            if (got !== m_out() || mem_timeout !== m_to) begin
                bad++;
                $display("FAIL timeout step%0d got=%b/%b want=%b/%b",
                         i, got, mem_timeout, m_out(), m_to);
            end
            if (i == 5 || i == 6 || i == 9 || i == 11) begin
                total++;
                if (mem_timeout !== (i == 6 || i == 9)) begin
                    bad++;
                    $display("FAIL timeout_flag step%0d got=%b", i,
                             mem_timeout);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_in();
            reset = ($urandom_range(0, 49) == 0);
            #1;
            total++;
            if (got !== m_out() || mem_timeout !== m_to) begin
                bad++;
                $display("FAIL random cyc%0d got=%b/%b want=%b/%b",
                         i, got, mem_timeout, m_out(), m_to);
            end
`ifdef PIPE_PERF_CNT_EN
            total++;
            if (stall_cycles !== PW'(m_stall) ||
                flush_events !== PW'(m_flush)) begin
                bad++;
                $display("FAIL random_perf cyc%0d got=%0d/%0d want=%0d/%0d",
                         i, stall_cycles, flush_events,
                         PW'(m_stall), PW'(m_flush));
            end
`endif
            tick();
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_in();
            case (i)
                0: reset = 1;
                1: set_lu(5, 5, 0, 1, 0);
                2: ;
                3: begin ex_valid = 1; ex_br_taken = 1; end
                4: begin ex_valid = 1; ex_br_taken = 1; ex_br_annul = 1; end
                default: begin ex_valid = 1; ex_br_annul = 1; end
            endcase
            tick();
        end
        @(negedge clk);
        idle_in();
        #1;
        total++;
        if (stall_cycles !== 4'd1 || flush_events !== 4'd3) begin
            bad++;
            $display("FAIL perf_basic got=%0d/%0d want=1/3",
                     stall_cycles, flush_events);
        end
        reset = 1;
        tick();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idle_in();
            mem_req = 1;
            tick();
        end
        @(negedge clk);
        #1;
        total++;
        if (stall_cycles !== 4'd1) begin
            bad++;
            $display("FAIL perf_wrap got=%0d want=1", stall_cycles);
        end
        reset = 1;
        tick();
    endtask
`endif

    initial begin
        idle_in();
        reset = 1;
        m_wait = 0; m_trap = 0; m_to = 0; m_cnt = 0;
        m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_memwait();
        test_timeout();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
